logic_gate_pipe: RTL and testbench

Parametrised, pipelined multi-function bitwise gate unit. It generalises the single-bit NOT/AND/OR gates to WIDTH-bit operands with eight selectable logic modes. Operands travel through a two-stage valid/ready pipeline, and the unit produces zero/all-ones flags and a completed-transaction counter. It sits between operand sources and any downstream consumer that needs registered, back-pressurable bitwise logic.

---
 rtl/logic_gate_pipe_if.sv | 28 ++
 rtl/logic_gate_pipe.sv | 108 ++++++++++
 tb/tb_logic_gate_pipe.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_gate_pipe_if.sv
// Operand/result bundle for logic_gate_pipe: valid/ready input beat, valid/ready result beat, counter.
// master drives operands and out_ready; slave is the gate unit.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ones;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ones, txn_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ones, txn_count
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Two-stage bitwise gate unit (8 modes) with zero/ones flags; result 2 edges after accept, 1 beat/cycle.
// Back-pressure: out_ready low fills both stages, then in_ready drops (only out_ready -> in_ready is combinational).
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  logic_gate_pipe_if.slave   bus
);

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_dat_t;

  logic             s1_valid_q, s1_valid_d;
  s1_dat_t          s1_dat_q, s1_dat_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_zero_q, out_zero_d;
  logic             out_ones_q, out_ones_d;
  logic [CNT_W-1:0] txn_count_q, txn_count_d;

  logic             s2_adv;
  logic             s1_adv;
  logic [WIDTH-1:0] result;

  always_comb begin
    result = s1_dat_q.a;
    case (s1_dat_q.op)
      3'd0: result = ~s1_dat_q.a;
      3'd1: result = s1_dat_q.a & s1_dat_q.b;
      3'd2: result = s1_dat_q.a | s1_dat_q.b;
      3'd3: result = s1_dat_q.a ^ s1_dat_q.b;
      3'd4: result = ~(s1_dat_q.a & s1_dat_q.b);
      3'd5: result = ~(s1_dat_q.a | s1_dat_q.b);
      3'd6: result = ~(s1_dat_q.a ^ s1_dat_q.b);
      3'd7: result = s1_dat_q.a;
      default: result = s1_dat_q.a;
    endcase
  end

  always_comb begin
    s2_adv      = !out_valid_q || bus.out_ready;
    s1_adv      = !s1_valid_q || s2_adv;

    s1_valid_d  = s1_valid_q;
    s1_dat_d    = s1_dat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    out_ones_d  = out_ones_q;
    txn_count_d = txn_count_q;

    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_dat_d.op = bus.in_op;
        s1_dat_d.a  = bus.in_a;
        s1_dat_d.b  = bus.in_b;
      end
    end

    // Result and flags only change when a real beat moves into S2.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = result;
        out_zero_d = (result == '0);
        out_ones_d = (result == '1);
      end
    end

    if (out_valid_q && bus.out_ready) begin
      txn_count_d = txn_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_dat_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_ones_q  <= 1'b0;
      txn_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dat_q    <= s1_dat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_ones_q  <= out_ones_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ones  = out_ones_q;
  assign bus.txn_count = txn_count_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: directed mode/flag table, back-pressure, counter wrap, reset, random stress.
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
  logic_gate_pipe_if #(.WIDTH(1), .CNT_W(2))  bus1 ();

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  logic_gate_pipe #(.WIDTH(1), .CNT_W(2))  u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per-bit truth tables indexed by {a_bit, b_bit}, one per mode.
  logic [3:0] tt [8];

  typedef struct {
    logic [7:0] d;
    int         acc;
  } beat_t;
  beat_t q[$];
  logic [9:0] cap[$];   // {zero, ones, data} of each output handshake

  int         mdl_txn;
  logic       prev_stall;
  logic [7:0] prev_d;
  logic       prev_z, prev_o;
  logic       last_hs_in;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_z;
    logic       exp_o;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [3:0] t;
    t = tt[op];
    for (int i = 0; i < 8; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  // One clock cycle on u0 with inputs already driven; checks against the queue model.
  task automatic tick();
    beat_t b;
    #2;
    chk("in_ready", 32'(bus0.in_ready), 32'((q.size() < 2) || bus0.out_ready));
    chk("out_valid", 32'(bus0.out_valid), 32'(q.size() > 0 && cyc >= q[0].acc + 2));
    chk("txn_count", 32'(bus0.txn_count), mdl_txn & 32'hFFFF);
    if (prev_stall) begin
      chk("stall_valid", 32'(bus0.out_valid), 32'd1);
      chk("stall_data", 32'(bus0.out_data), 32'(prev_d));
      chk("stall_flags", 32'({bus0.out_zero, bus0.out_ones}), 32'({prev_z, prev_o}));
    end
    if (bus0.out_valid && q.size() > 0) begin
      chk("out_data", 32'(bus0.out_data), 32'(q[0].d));
      chk("out_zero", 32'(bus0.out_zero), 32'(q[0].d == 8'h00));
      chk("out_ones", 32'(bus0.out_ones), 32'(q[0].d == 8'hFF));
    end
    last_hs_in = bus0.in_valid && bus0.in_ready;
    if (bus0.out_valid && bus0.out_ready) begin
      cap.push_back({bus0.out_zero, bus0.out_ones, bus0.out_data});
      if (q.size() > 0) void'(q.pop_front());
      mdl_txn++;
    end
    if (last_hs_in) begin
      b.d   = ref_fn(bus0.in_op, bus0.in_a, bus0.in_b);
      b.acc = cyc;
      q.push_back(b);
    end
    prev_stall = bus0.out_valid && !bus0.out_ready;
    prev_d     = bus0.out_data;
    prev_z     = bus0.out_zero;
    prev_o     = bus0.out_ones;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int         wseq[5];
    int         k;
    int         idx;
    logic       hs;
    logic [7:0] bp_a[4];
    int         base_txn;
    int         n_acc;

    tt[0] = 4'b0011; tt[1] = 4'b1000; tt[2] = 4'b1110; tt[3] = 4'b0110;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001; tt[7] = 4'b1100;

    vt[0] = '{3'd0, 8'hA5, 8'h3C, 8'h5A, 1'b0, 1'b0};
    vt[1] = '{3'd1, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0};
    vt[2] = '{3'd2, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0};
    vt[3] = '{3'd3, 8'hA5, 8'h3C, 8'h99, 1'b0, 1'b0};
    vt[4] = '{3'd4, 8'hA5, 8'h3C, 8'hDB, 1'b0, 1'b0};
    vt[5] = '{3'd5, 8'hA5, 8'h3C, 8'h42, 1'b0, 1'b0};
    vt[6] = '{3'd6, 8'hA5, 8'h3C, 8'h66, 1'b0, 1'b0};
    vt[7] = '{3'd7, 8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0};
    vt[8] = '{3'd1, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
    vt[9] = '{3'd2, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1};

    wseq = '{1, 2, 3, 0, 1};
    bp_a = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_op = 3'd0; bus0.in_a = 8'h00; bus0.in_b = 8'h00; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_op = 3'd0; bus1.in_a = 1'b0;  bus1.in_b = 1'b0;  bus1.out_ready = 1'b0;
    mdl_txn = 0; prev_stall = 1'b0; prev_d = 8'h00; prev_z = 1'b0; prev_o = 1'b0; last_hs_in = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus0.out_data), 32'd0);
    chk("rst_flags", 32'({bus0.out_zero, bus0.out_ones}), 32'd0);
    chk("rst_txn", 32'(bus0.txn_count), 32'd0);
    chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); cyc++; #1;

    // Counter wrap on the CNT_W=2, WIDTH=1 instance; results alternate 1,0,...
    bus1.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      bus1.in_valid = (c < 5);
      bus1.in_op    = (c % 2 == 0) ? 3'd7 : 3'd0;
      bus1.in_a     = 1'b1;
      #2;
      hs = bus1.out_valid && bus1.out_ready;
      if (bus1.out_valid) begin
        chk("w1_data", 32'(bus1.out_data), 32'(k % 2 == 0));
        chk("w1_ones", 32'(bus1.out_ones), 32'(k % 2 == 0));
        chk("w1_zero", 32'(bus1.out_zero), 32'(k % 2 != 0));
      end
      @(posedge clk); cyc++; #1;
      if (hs && k < 5) begin
        chk("wrap_txn", 32'(bus1.txn_count), 32'(wseq[k]));
        k++;
      end
    end
    chk("wrap_count", 32'(k), 32'd5);
    bus1.in_valid = 1'b0;

    // All modes back to back, then flag vectors
    cap.delete();
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus0.in_valid = 1'b1; bus0.in_op = vt[i].op; bus0.in_a = vt[i].a; bus0.in_b = vt[i].b;
      tick();
      chk("tbl_accept", 32'(last_hs_in), 32'd1);
    end
    drain();
    chk("tbl_txn8", 32'(bus0.txn_count), 32'd8);
    for (int i = 8; i < 10; i++) begin
      bus0.in_valid = 1'b1; bus0.in_op = vt[i].op; bus0.in_a = vt[i].a; bus0.in_b = vt[i].b;
      tick();
    end
    drain();
    chk("tbl_ncap", 32'(cap.size()), 32'd10);
    for (int i = 0; i < 10 && i < cap.size(); i++) begin
      chk("tbl_data", 32'(cap[i][7:0]), 32'(vt[i].exp_d));
      chk("tbl_flags", 32'(cap[i][9:8]), 32'({vt[i].exp_z, vt[i].exp_o}));
    end

    // Back-pressure: only two beats fit while the consumer stalls
    cap.delete();
    idx = 0;
    bus0.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus0.in_valid = 1'b1; bus0.in_op = 3'd7; bus0.in_a = bp_a[idx]; bus0.in_b = 8'h00;
      tick();
      if (last_hs_in) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(bus0.in_ready), 32'd0);
    bus0.out_ready = 1'b1;
    for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
      bus0.in_valid = (idx < 4);
      bus0.in_a     = bp_a[idx < 4 ? idx : 3];
      tick();
      if (last_hs_in) idx++;
    end
    bus0.in_valid = 1'b0;
    chk("bp_ncap", 32'(cap.size()), 32'd4);
    for (int i = 0; i < 4 && i < cap.size(); i++) chk("bp_order", 32'(cap[i][7:0]), 32'(bp_a[i]));

    // Random stress
    base_txn = mdl_txn;
    n_acc = 0;
    for (int c = 0; c < 1500; c++) begin
      bus0.in_valid  = ($urandom_range(0, 99) < 70);
      bus0.out_ready = ($urandom_range(0, 99) < 60);
      bus0.in_op     = 3'($urandom);
      bus0.in_a      = 8'($urandom);
      bus0.in_b      = 8'($urandom);
      tick();
      if (last_hs_in) n_acc++;
    end
    drain();
    chk("rand_txn_total", 32'(bus0.txn_count), 32'((base_txn + n_acc) & 32'hFFFF));

    // Reset with both stages full, beat held valid through reset
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1; bus0.in_op = 3'd7; bus0.in_a = 8'h77;
    tick();
    tick();
    chk("pre_rst_full", 32'(bus0.in_ready), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(bus0.out_data), 32'd0);
    chk("mid_rst_txn", 32'(bus0.txn_count), 32'd0);
    chk("mid_rst_in_ready", 32'(bus0.in_ready), 32'd1);
    q.delete(); cap.delete(); mdl_txn = 0; prev_stall = 1'b0;
    @(posedge clk); cyc++; #1;
    chk("in_rst_out_valid", 32'(bus0.out_valid), 32'd0);
    #2 bus0.in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); cyc++; #1;
    bus0.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("post_rst_no_stale", 32'(cap.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
